// File: rtl/ddf_tag_demux.sv
// Tagged-result demux: pops {tag,sum} words from a FWFT FIFO and
// steers each sum into one of two per-flow FIFOs, in strict order.
//
// Ports:
//   ck, rst          clock, synchronous active-high reset
//   in_empty/in_data upstream FWFT FIFO head; in_read pops it
//   outN_full        flow-N FIFO full flag (N = 0, 1)
//   outN_wr/outN_data write strobe and data to flow-N FIFO
//   cnt0, cnt1       words delivered per flow (wrapping)
//   busy             holding register has an undelivered word
module ddf_tag_demux #(
  parameter int WIDTH     = 33,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 ck,
  input  logic                 rst,
  input  logic                 in_empty,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 in_read,
  input  logic                 out0_full,
  output logic                 out0_wr,
  output logic [WIDTH-2:0]     out0_data,
  input  logic                 out1_full,
  output logic                 out1_wr,
  output logic [WIDTH-2:0]     out1_data,
  output logic [CNT_WIDTH-1:0] cnt0,
  output logic [CNT_WIDTH-1:0] cnt1,
  output logic                 busy
);

  logic             hold_valid;
  logic             hold_tag;
  logic [WIDTH-2:0] hold_data;

  logic tgt_full;
  logic drain;

  // Only the target flow's full flag matters; a full target stalls
  // the whole stream (head-of-line blocking).
  assign tgt_full = hold_tag ? out1_full : out0_full;
  assign drain    = ~rst & hold_valid & ~tgt_full;

  // EMPTY reads whenever data exists; LOADED reads only while the
  // held word leaves in the same cycle (back-to-back).
  assign in_read = ~rst & ~in_empty
                 & (~hold_valid | drain);

  assign out0_wr   = drain & ~hold_tag;
  assign out1_wr   = drain &  hold_tag;
  assign out0_data = hold_data;
  assign out1_data = hold_data;
  assign busy      = hold_valid;

  always_ff @(posedge ck) begin
    if (rst) begin
      hold_valid <= 1'b0;
      hold_tag   <= 1'b0;
      hold_data  <= '0;
      cnt0       <= '0;
      cnt1       <= '0;
    end else begin
      if (in_read) begin
        hold_valid <= 1'b1;
        hold_tag   <= in_data[WIDTH-1];
        hold_data  <= in_data[WIDTH-2:0];
      end else if (drain) begin
        hold_valid <= 1'b0;
      end
      if (out0_wr) cnt0 <= cnt0 + 1'b1;
      if (out1_wr) cnt1 <= cnt1 + 1'b1;
    end
  end

endmodule

// File: tb/tb_ddf_tag_demux.sv
// Bench for ddf_tag_demux: directed literal checks plus a
// queue-based reference model compared on every cycle.
module tb_ddf_tag_demux;

  localparam int W  = 33;
  localparam int CW = 16;

  logic          ck = 1'b0;
  logic          rst = 1'b1;
  logic          in_empty = 1'b1;
  logic [W-1:0]  in_data = '0;
  logic          in_read;
  logic          out0_full = 1'b0;
  logic          out0_wr;
  logic [W-2:0]  out0_data;
  logic          out1_full = 1'b0;
  logic          out1_wr;
  logic [W-2:0]  out1_data;
  logic [CW-1:0] cnt0;
  logic [CW-1:0] cnt1;
  logic          busy;

  int tests = 0;
  int fails = 0;

  ddf_tag_demux #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
    .ck(ck), .rst(rst),
    .in_empty(in_empty), .in_data(in_data),
    .in_read(in_read),
    .out0_full(out0_full), .out0_wr(out0_wr),
    .out0_data(out0_data),
    .out1_full(out1_full), .out1_wr(out1_wr),
    .out1_data(out1_data),
    .cnt0(cnt0), .cnt1(cnt1), .busy(busy)
  );

  always #5 ck = ~ck;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  // Reference model: the set of words popped but not yet
  // delivered, plus per-flow delivery counts.
  logic [W-1:0]  m_q[$];
  logic [CW-1:0] m_c0 = '0;
  logic [CW-1:0] m_c1 = '0;
  bit            armed = 0;

  always @(negedge ck) begin
    bit           have, tag, full_t, drn, rd;
    logic [W-2:0] d;
    have = (m_q.size() != 0);
    tag  = have ? m_q[0][W-1] : 1'b0;
    d    = have ? m_q[0][W-2:0] : '0;
    full_t = tag ? out1_full : out0_full;
    drn  = !rst && have && !full_t;
    rd   = !rst && !in_empty && (!have || drn);
    if (rst) armed = 1;
    if (armed) begin
      chk("m_in_read", 64'(in_read), 64'(rd));
      chk("m_wr0", 64'(out0_wr), 64'(drn && !tag));
      chk("m_wr1", 64'(out1_wr), 64'(drn && tag));
      chk("m_excl", 64'(out0_wr & out1_wr), 64'd0);
      chk("m_busy", 64'(busy), 64'(have));
      chk("m_cnt0", 64'(cnt0), 64'(m_c0));
      chk("m_cnt1", 64'(cnt1), 64'(m_c1));
      if (have) begin
        chk("m_d0", 64'(out0_data), 64'(d));
        chk("m_d1", 64'(out1_data), 64'(d));
      end
    end
    if (rst) begin
      m_q.delete();
      m_c0 = '0;
      m_c1 = '0;
    end else begin
      if (drn) begin
        void'(m_q.pop_front());
        if (tag) m_c1 = m_c1 + 1'b1;
        else     m_c0 = m_c0 + 1'b1;
      end
      if (rd) m_q.push_back(in_data);
    end
  end

  task automatic step();
    @(posedge ck);
    #1;
  endtask

  task automatic at_neg();
    @(negedge ck);
  endtask

  function automatic logic [W-1:0] mk(input bit t,
                                      input logic [31:0] v);
    return {t, v};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    in_empty = 1'b1;
    out0_full = 1'b0;
    out1_full = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    step();
    do_reset();

    // Reset state
    at_neg();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_cnt0", 64'(cnt0), 64'd0);
    chk("rst_cnt1", 64'(cnt1), 64'd0);
    chk("rst_data", 64'(out0_data), 64'd0);
    step();

    // Three-word stream, no full
    in_empty = 1'b0;
    in_data = mk(1, 32'h5);
    at_neg();
    chk("s_c0_rd", 64'(in_read), 64'd1);
    chk("s_c0_wr1", 64'(out1_wr), 64'd0);
    step();
    in_data = mk(0, 32'hA);
    at_neg();
    chk("s_c1_rd", 64'(in_read), 64'd1);
    chk("s_c1_wr1", 64'(out1_wr), 64'd1);
    chk("s_c1_d1", 64'(out1_data), 64'h5);
    step();
    in_data = mk(1, 32'hFFFF_FFFF);
    at_neg();
    chk("s_c2_rd", 64'(in_read), 64'd1);
    chk("s_c2_wr0", 64'(out0_wr), 64'd1);
    chk("s_c2_d0", 64'(out0_data), 64'hA);
    step();
    in_empty = 1'b1;
    at_neg();
    chk("s_c3_wr1", 64'(out1_wr), 64'd1);
    chk("s_c3_d1", 64'(out1_data), 64'hFFFF_FFFF);
    chk("s_c3_rd", 64'(in_read), 64'd0);
    step();
    step();
    at_neg();
    chk("s_cnt0", 64'(cnt0), 64'd1);
    chk("s_cnt1", 64'(cnt1), 64'd2);
    chk("s_busy", 64'(busy), 64'd0);
    step();

    // Stall on flow-0 full for four cycles
    out0_full = 1'b1;
    in_empty = 1'b0;
    in_data = mk(0, 32'h7);
    at_neg();
    chk("st_rd0", 64'(in_read), 64'd1);
    step();
    in_data = mk(1, 32'h9);
    for (int i = 0; i < 4; i++) begin
      at_neg();
      chk("st_rd", 64'(in_read), 64'd0);
      chk("st_wr", 64'(out0_wr | out1_wr), 64'd0);
      chk("st_busy", 64'(busy), 64'd1);
      step();
    end
    out0_full = 1'b0;
    at_neg();
    chk("st_rel_wr0", 64'(out0_wr), 64'd1);
    chk("st_rel_d0", 64'(out0_data), 64'h7);
    chk("st_rel_rd", 64'(in_read), 64'd1);
    step();
    in_empty = 1'b1;
    at_neg();
    chk("st_nx_wr1", 64'(out1_wr), 64'd1);
    chk("st_nx_d1", 64'(out1_data), 64'h9);
    step();
    step();

    // Reset while holding an undeliverable word
    do_reset();
    out1_full = 1'b1;
    in_empty = 1'b0;
    in_data = mk(1, 32'h3);
    at_neg();
    chk("rm_rd", 64'(in_read), 64'd1);
    step();
    in_empty = 1'b1;
    at_neg();
    chk("rm_busy", 64'(busy), 64'd1);
    chk("rm_wr1", 64'(out1_wr), 64'd0);
    step();
    rst = 1'b1;
    in_empty = 1'b0;
    out1_full = 1'b0;
    at_neg();
    chk("rm_rd_rst", 64'(in_read), 64'd0);
    chk("rm_wr_rst", 64'(out1_wr), 64'd0);
    step();
    rst = 1'b0;
    in_empty = 1'b1;
    at_neg();
    chk("rm_busy2", 64'(busy), 64'd0);
    chk("rm_cnt1", 64'(cnt1), 64'd0);
    chk("rm_wr1b", 64'(out1_wr), 64'd0);
    step();

    // Counter wrap on flow 0
    do_reset();
    in_empty = 1'b0;
    for (int i = 0; i < 65535; i++) begin
      in_data = mk(0, $urandom);
      step();
    end
    in_empty = 1'b1;
    step();
    step();
    at_neg();
    chk("wr_max", 64'(cnt0), 64'hFFFF);
    step();
    in_empty = 1'b0;
    in_data = mk(0, 32'h1234);
    step();
    in_empty = 1'b1;
    step();
    step();
    at_neg();
    chk("wr_wrap0", 64'(cnt0), 64'd0);
    chk("wr_cnt1", 64'(cnt1), 64'd0);
    step();

    // Toggling empty, alternating tags: 100 words
    do_reset();
    for (int i = 0; i < 200; i++) begin
      in_empty = i[0];
      in_data = mk(i[1], $urandom);
      step();
    end
    in_empty = 1'b1;
    step();
    step();
    at_neg();
    chk("tg_cnt0", 64'(cnt0), 64'd50);
    chk("tg_cnt1", 64'(cnt1), 64'd50);
    step();

    // Fully random traffic, full flags and resets
    for (int i = 0; i < 2000; i++) begin
      in_empty = ($urandom_range(0, 2) == 0);
      in_data = {$urandom_range(0, 1) == 1, 32'($urandom)};
      out0_full = ($urandom_range(0, 3) == 0);
      out1_full = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0;
    in_empty = 1'b1;
    out0_full = 1'b0;
    out1_full = 1'b0;
    step();
    step();
    at_neg();
    chk("rnd_idle", 64'(busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
